// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM between a CPU port and a DMA port using fixed-length access cycles.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is CPU priority with a DMA starvation guard.
module mem_arbiter #(
  parameter int ACC_CYCLES = 2,
  parameter int MAX_WAIT   = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [19:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        Data_oe,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] ACC_LAST = 4'(ACC_CYCLES - 1);

  state_t      r_state, w_state_next;
  logic [3:0]  r_acc_cnt, w_acc_cnt_next;
  logic        r_owner_dma, w_owner_dma_next;
  logic        r_op_we, w_op_we_next;
  logic [19:0] r_addr, w_addr_next;
  logic [15:0] r_wdata, w_wdata_next;
  logic        r_oe_n, w_oe_n_next;
  logic        r_we_n, w_we_n_next;
  logic        r_data_oe, w_data_oe_next;
  logic        r_cpu_ack, w_cpu_ack_next;
  logic        r_dma_ack, w_dma_ack_next;
  logic [15:0] r_cpu_rdata, w_cpu_rdata_next;
  logic [15:0] r_dma_rdata, w_dma_rdata_next;
  logic        r_busy;
  logic        w_arb;
  logic        w_grant_dma;

  assign w_arb = (r_state == IDLE) && (cpu_req || dma_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_dma;

  // On conflict the port that did not win last time gets the bus.
  assign w_grant_dma = (cpu_req && dma_req) ? !r_last_dma : dma_req;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_last_dma <= 1'b1;
    end else if (w_arb) begin
      r_last_dma <= w_grant_dma;
    end
  end
`else
  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  logic [7:0] r_wait;

  assign w_grant_dma = dma_req && (!cpu_req || (r_wait == WAIT_LIM));

  // Counts conflicts DMA has lost in a row; saturates rather than wrapping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wait <= '0;
    end else if (w_arb && w_grant_dma) begin
      r_wait <= '0;
    end else if (w_arb && cpu_req && dma_req && (r_wait != 8'hFF)) begin
      r_wait <= r_wait + 8'd1;
    end
  end
`endif

  always_comb begin
    w_state_next     = r_state;
    w_acc_cnt_next   = r_acc_cnt;
    w_owner_dma_next = r_owner_dma;
    w_op_we_next     = r_op_we;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
    w_oe_n_next      = 1'b1;
    w_we_n_next      = 1'b1;
    w_data_oe_next   = 1'b0;
    w_cpu_ack_next   = 1'b0;
    w_dma_ack_next   = 1'b0;
    w_cpu_rdata_next = r_cpu_rdata;
    w_dma_rdata_next = r_dma_rdata;
    case (r_state)
      IDLE: begin
        if (w_arb) begin
          w_state_next     = ACCESS;
          w_acc_cnt_next   = '0;
          w_owner_dma_next = w_grant_dma;
          w_op_we_next     = w_grant_dma ? dma_we    : cpu_we;
          w_addr_next      = w_grant_dma ? dma_addr  : cpu_addr;
          w_wdata_next     = w_grant_dma ? dma_wdata : cpu_wdata;
          w_oe_n_next      = w_op_we_next;
          w_we_n_next      = !w_op_we_next;
          w_data_oe_next   = w_op_we_next;
        end
      end
      ACCESS: begin
        if (r_acc_cnt == ACC_LAST) begin
          // Last strobe edge: sample read data and raise the owner's ack for DONE.
          w_state_next = DONE;
          if (!r_op_we && !r_owner_dma) w_cpu_rdata_next = Data_from_SRAM;
          if (!r_op_we && r_owner_dma)  w_dma_rdata_next = Data_from_SRAM;
          w_cpu_ack_next = !r_owner_dma;
          w_dma_ack_next = r_owner_dma;
        end else begin
          w_acc_cnt_next = r_acc_cnt + 4'd1;
          w_oe_n_next    = r_op_we;
          w_we_n_next    = !r_op_we;
          w_data_oe_next = r_op_we;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_acc_cnt   <= '0;
      r_owner_dma <= 1'b0;
      r_op_we     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_data_oe   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc_cnt   <= w_acc_cnt_next;
      r_owner_dma <= w_owner_dma_next;
      r_op_we     <= w_op_we_next;
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_oe_n      <= w_oe_n_next;
      r_we_n      <= w_we_n_next;
      r_data_oe   <= w_data_oe_next;
      r_cpu_ack   <= w_cpu_ack_next;
      r_dma_ack   <= w_dma_ack_next;
      r_cpu_rdata <= w_cpu_rdata_next;
      r_dma_rdata <= w_dma_rdata_next;
      r_busy      <= (w_state_next != IDLE);
    end
  end

  assign ADDR         = r_addr;
  assign Data_to_SRAM = r_wdata;
  assign Data_oe      = r_data_oe;
  assign Mem_OE       = r_oe_n;
  assign Mem_WE       = r_we_n;
  assign cpu_ack      = r_cpu_ack;
  assign dma_ack      = r_dma_ack;
  assign cpu_rdata    = r_cpu_rdata;
  assign dma_rdata    = r_dma_rdata;
  assign busy         = r_busy;
  assign Mem_CE       = 1'b0;
  assign Mem_UB       = 1'b0;
  assign Mem_LB       = 1'b0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: port drivers push expected responses, a monitor pops them on every ack.
// Port 0 is the CPU (address bit 7 clear), port 1 the DMA (address bit 7 set), so their data never aliases.
module tb_mem_arbiter;

  localparam int ACC = 2;
  localparam int MW  = 8;

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    bit          hold;
    int          gap;
  } stim_t;

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        p_req   [2];
  logic        p_we    [2];
  logic [19:0] p_addr  [2];
  logic [15:0] p_wdata [2];
  logic        cpu_ack, dma_ack;
  logic [15:0] cpu_rdata, dma_rdata;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM, Data_from_SRAM;
  logic        Data_oe, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  stim_t stim_q [2][$];
  exp_t  exp_q  [2][$];
  bit    order_q [$];

  logic [15:0] sram [256];
  logic        sram_ready = 1'b0;

  mem_arbiter #(.ACC_CYCLES(ACC), .MAX_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(p_req[0]), .cpu_we(p_we[0]), .cpu_addr(p_addr[0]), .cpu_wdata(p_wdata[0]),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(p_req[1]), .dma_we(p_we[1]), .dma_addr(p_addr[1]), .dma_wdata(p_wdata[1]),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .Data_oe(Data_oe), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .busy(busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [15:0] sram_init(input logic [7:0] i);
    if (i == 8'h10) return 16'h1234;
    return ({8'h00, i} * 16'h9E37) ^ 16'h5C3A;
  endfunction

  // SRAM model: 256 words, indexed by the low address byte.
  always @(posedge Clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 256; i++) sram[i] <= sram_init(8'(i));
      sram_ready <= 1'b1;
    end else if (!Mem_WE) begin
      sram[ADDR[7:0]] <= Data_to_SRAM;
    end
  end
  assign Data_from_SRAM = Mem_OE ? 16'hDEAD : sram[ADDR[7:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- driver: one process owns both ports ----------------
  logic [15:0] ref_mem [2][256];
  logic [15:0] last_rd [2];
  stim_t       cur     [2];
  int          gap_left[2];

  task automatic issue(input int p);
    exp_t e;
    cur[p] = stim_q[p].pop_front();
    p_we[p]    = cur[p].we;
    p_addr[p]  = cur[p].addr;
    p_wdata[p] = cur[p].wdata;
    p_req[p]   = 1'b1;
    if (cur[p].we) ref_mem[p][cur[p].addr[7:0]] = cur[p].wdata;
    else           last_rd[p] = ref_mem[p][cur[p].addr[7:0]];
    e.we = cur[p].we; e.addr = cur[p].addr; e.wdata = cur[p].wdata; e.rdata = last_rd[p];
    exp_q[p].push_back(e);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 256; i++) ref_mem[p][i] = sram_init(8'(i));
      p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
      last_rd[p] = '0; gap_left[p] = 0;
    end
    forever begin
      @(negedge Clk);
      for (int p = 0; p < 2; p++) begin
        logic ack_p;
        ack_p = (p == 0) ? cpu_ack : dma_ack;
        if (Reset) begin
          p_req[p] = 1'b0; gap_left[p] = 0; last_rd[p] = '0;
          exp_q[p].delete();
        end else if (p_req[p]) begin
          if (ack_p) begin
            if (cur[p].hold && stim_q[p].size() > 0) issue(p);
            else begin p_req[p] = 1'b0; gap_left[p] = cur[p].gap; end
          end
        end else if (gap_left[p] > 0) begin
          gap_left[p]--;
        end else if (stim_q[p].size() > 0) begin
          issue(p);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic        prev_busy = 1'b0;
  int          start_cyc, oe_low, we_low, doe_cnt, ord_prev = -1;
  logic [19:0] acc_addr;
  logic        addr_moved;
  exp_t        mon_e;
  bit          exp_port;

  always @(negedge Clk) begin
    if (Reset) begin
      prev_busy = 1'b0;
      ord_prev  = -1;
    end else begin
      chk("single_ack", 32'(cpu_ack && dma_ack), 32'd0);
      chk("no_contention", 32'(Data_oe && !Mem_OE), 32'd0);
      if (busy && !prev_busy) begin
        start_cyc = cyc; oe_low = 0; we_low = 0; doe_cnt = 0;
        acc_addr = ADDR; addr_moved = 1'b0;
      end
      if (busy && ADDR !== acc_addr) addr_moved = 1'b1;
      if (!Mem_OE) oe_low++;
      if (!Mem_WE) we_low++;
      if (Data_oe) doe_cnt++;
      prev_busy = busy;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? cpu_ack : dma_ack) begin
          chk("ack_expected", 32'(exp_q[p].size() > 0), 32'd1);
          if (exp_q[p].size() > 0) begin
            mon_e = exp_q[p].pop_front();
            $display("ack %s we=%0d addr=%05h wdata=%04h rdata=%04h t=%0t",
                     (p == 0) ? "cpu" : "dma", mon_e.we, mon_e.addr, mon_e.wdata,
                     (p == 0) ? cpu_rdata : dma_rdata, $time);
            chk("ack_addr", 32'(ADDR), 32'(mon_e.addr));
            chk("rdata", 32'((p == 0) ? cpu_rdata : dma_rdata), 32'(mon_e.rdata));
            chk("latency", 32'(cyc - start_cyc), 32'(ACC));
            chk("addr_stable", 32'(addr_moved), 32'd0);
            chk("busy_in_done", 32'(busy), 32'd1);
            if (mon_e.we) begin
              chk("we_low_cycles", 32'(we_low), 32'(ACC));
              chk("oe_low_on_write", 32'(oe_low), 32'd0);
              chk("data_oe_cycles", 32'(doe_cnt), 32'(ACC));
              chk("wdata_bus", 32'(Data_to_SRAM), 32'(mon_e.wdata));
              chk("sram_written", 32'(sram[mon_e.addr[7:0]]), 32'(mon_e.wdata));
            end else begin
              chk("oe_low_cycles", 32'(oe_low), 32'(ACC));
              chk("we_low_on_read", 32'(we_low), 32'd0);
              chk("data_oe_on_read", 32'(doe_cnt), 32'd0);
            end
            if (order_q.size() > 0) begin
              exp_port = order_q.pop_front();
              chk("grant_port", 32'(p), 32'(exp_port));
              if (ord_prev >= 0) chk("b2b_period", 32'(cyc - ord_prev), 32'(ACC + 2));
              ord_prev = cyc;
            end
          end
        end
      end
    end
  end

  // ---------------- reference arbitration order ----------------
  // Both ports start pending together right after reset; each keeps requesting until its list is empty.
  task automatic build_order(input int nc, input int nd);
    int w = 0;
    bit last_dma = 1'b1;
    bit pick_dma;
    while (nc > 0 || nd > 0) begin
      if (nc > 0 && nd > 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_dma = !last_dma;
`else
        pick_dma = (w >= MW);
        if (!pick_dma && w < 255) w++;
`endif
      end else begin
        pick_dma = (nd > 0);
      end
      if (pick_dma) begin nd--; w = 0; end
      else nc--;
      last_dma = pick_dma;
      order_q.push_back(pick_dma);
    end
  endtask

  task automatic push_stim(input int p, input logic we, input logic [19:0] a,
                           input logic [15:0] d, input bit hold, input int gap);
    stim_t s;
    s.we = we; s.addr = a; s.wdata = d; s.hold = hold; s.gap = gap;
    stim_q[p].push_back(s);
  endtask

  task automatic wait_idle(input int budget);
    int  n = 0;
    bit  pending;
    do begin
      @(negedge Clk);
      n++;
      pending = stim_q[0].size() > 0 || stim_q[1].size() > 0 || exp_q[0].size() > 0 ||
                exp_q[1].size() > 0 || p_req[0] || p_req[1];
    end while (pending && n < budget);
    chk("drain_timeout", 32'(pending), 32'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    order_q.delete();
    Reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [19:0] a;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_mem_oe", 32'(Mem_OE), 32'd1);
    chk("rst_mem_we", 32'(Mem_WE), 32'd1);
    chk("rst_data_oe", 32'(Data_oe), 32'd0);
    chk("rst_addr", 32'(ADDR), 32'd0);
    chk("rst_wdata", 32'(Data_to_SRAM), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_dma_rdata", 32'(dma_rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("mem_ce", 32'(Mem_CE), 32'd0);
    chk("mem_ub_lb", 32'({Mem_UB, Mem_LB}), 32'd0);
    Reset = 1'b0;

    // Directed CPU read and DMA write
    @(posedge Clk);
    push_stim(0, 1'b0, 20'h00010, 16'h0000, 1'b0, 0);
    wait_idle(100);
    chk("cpu_read_0x10", 32'(cpu_rdata), 32'h1234);
    @(posedge Clk);
    push_stim(1, 1'b1, 20'hABCDE, 16'h5A5A, 1'b0, 0);
    wait_idle(100);
    chk("sram_0xABCDE", 32'(sram[8'hDE]), 32'h5A5A);

    // Reset lands on the last ACCESS edge of a CPU write
    @(posedge Clk);
    push_stim(0, 1'b1, 20'h00055, 16'hBEEF, 1'b0, 0);
    n = 0;
    do begin @(negedge Clk); n++; end while (!busy && n < 20);
    chk("abort_started", 32'(busy), 32'd1);
    @(negedge Clk);
    chk("abort_we_low", 32'(Mem_WE), 32'd0);
    chk("abort_data_oe", 32'(Data_oe), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_we_high", 32'(Mem_WE), 32'd1);
    chk("abort_data_oe_off", 32'(Data_oe), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_ack", 32'(cpu_ack), 32'd0);
    @(negedge Clk);
    order_q.delete();
    Reset = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      chk("abort_stays_quiet", 32'({cpu_ack, busy}), 32'd0);
    end
    @(posedge Clk);
    push_stim(0, 1'b0, 20'h00055, 16'h0000, 1'b0, 0);
    wait_idle(100);

    // Both ports requesting continuously from reset
    do_reset();
    @(posedge Clk);
    build_order(18, 2);
    for (int i = 0; i < 18; i++)
      push_stim(0, 1'($urandom_range(0, 1)), 20'($urandom()) & 20'hFFF7F, 16'($urandom()), 1'b1, 0);
    for (int i = 0; i < 2; i++)
      push_stim(1, 1'($urandom_range(0, 1)), 20'($urandom()) | 20'h00080, 16'($urandom()), 1'b1, 0);
    wait_idle(1000);
    chk("order_consumed", 32'(order_q.size()), 32'd0);

    // Back-to-back CPU reads holding req through IDLE
    do_reset();
    @(posedge Clk);
    build_order(3, 0);
    for (int i = 0; i < 3; i++)
      push_stim(0, 1'b0, 20'h00010 + 20'(i), 16'h0000, 1'b1, 0);
    wait_idle(200);
    chk("b2b_consumed", 32'(order_q.size()), 32'd0);

    // Random mixed traffic on both ports
    @(posedge Clk);
    for (int i = 0; i < 30; i++) begin
      a = 20'($urandom()) & 20'hFFF7F;
      push_stim(0, 1'($urandom_range(0, 1)), a, 16'($urandom()), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      a = 20'($urandom()) | 20'h00080;
      push_stim(1, 1'($urandom_range(0, 1)), a, 16'($urandom()), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    wait_idle(5000);

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single off-chip SRAM between two requesters: the CPU port, driven by the LC-3 control/datapath memory interface, and a DMA port used by the program loader and the display reader.
- Owns all SRAM strobes (Mem_CE/UB/LB/OE/WE), the address bus and the write-data drive enable.
- Sequences each access as a fixed multi-cycle SRAM cycle and returns a one-cycle acknowledge to the winning requester.

Parameters:
ACC_CYCLES, 2, number of cycles OE or WE is held low per access (legal range 1..15).
MAX_WAIT, 8, consecutive DMA-lost arbitrations after which DMA is forced to win once (legal range 1..255).

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access pending; level, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  20  CPU word address
cpu_wdata  in  16  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  16  CPU read data
dma_req  in  1  DMA access pending; level, held until dma_ack
dma_we  in  1  1=write, 0=read
dma_addr  in  20  DMA word address
dma_wdata  in  16  DMA write data
dma_ack  out  1  one-cycle completion pulse to DMA
dma_rdata  out  16  DMA read data
ADDR  out  20  SRAM address
Data_to_SRAM  out  16  SRAM write data
Data_from_SRAM  in  16  SRAM read data
Data_oe  out  1  1=FPGA drives SRAM data bus
Mem_CE, Mem_UB, Mem_LB  out  1 each  active-low; tied 0
Mem_OE, Mem_WE  out  1 each  active-low strobes
busy  out  1  1 whenever state != IDLE

Behaviour:
- All outputs are registered except the Mem_CE/UB/LB constants.
- Reset values:
  - State = IDLE; Mem_OE = 1, Mem_WE = 1, Data_oe = 0.
  - ADDR = 0, Data_to_SRAM = 0.
  - cpu_ack = 0, dma_ack = 0; cpu_rdata = 0, dma_rdata = 0.
  - busy = 0, wait counter = 0.
- Reset mid-access aborts it immediately: strobes return high next edge and no ack is issued.
- States:
  - IDLE: arbitrate when any req = 1.
    - Winner's we/addr/wdata are latched into an internal owner/op/ADDR/Data_to_SRAM.
    - Go to ACCESS with access counter = 0.
    - With no req, stay in IDLE.
  - ACCESS:
    - Read: Mem_OE = 0, Data_oe = 0.
    - Write: Mem_WE = 0, Data_oe = 1.
    - The counter increments each cycle; after ACC_CYCLES cycles, go to DONE.
    - For a read, Data_from_SRAM is captured into the owner's rdata on the last ACCESS edge.
  - DONE:
    - Strobes high, Data_oe = 0, owner's ack = 1 for exactly this cycle, then IDLE.
- Handshake:
  - A requester drops req on the edge where it samples ack = 1, so req is low in the following IDLE cycle.
  - Inputs are ignored outside IDLE.
  - rdata stays valid and stable until that port's next read completes.
  - Write ack carries no data, and rdata is unchanged.
- Latency: req high in IDLE → ACCESS for ACC_CYCLES cycles → ack in DONE. That is ACC_CYCLES+1 cycles from the IDLE edge to ack, and ACC_CYCLES+2 per back-to-back access including the IDLE turnaround.
- Arbitration (default build): fixed CPU priority with starvation guard.
  - The wait counter increments when both reqs = 1 in IDLE and CPU wins.
  - When the counter = MAX_WAIT, DMA wins and the counter clears.
  - The counter also clears on any DMA grant.
  - The counter saturates and does not wrap.
- Simultaneous req on both ports with counter < MAX_WAIT: CPU wins.
- Address and data are held constant for the whole ACCESS plus DONE period.
- The strobe-to-Data_oe relationship guarantees no bus contention: Data_oe is never 1 while Mem_OE = 0.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined:
  - Arbitration is strict round-robin; the port not granted last wins on conflict.
  - After reset, the last-granted port is DMA, so CPU wins the first conflict.
  - The wait counter and MAX_WAIT are not instantiated.
- Undefined: the fixed-priority-with-starvation-guard scheme above.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset, then CPU read addr 0x00010 with SRAM model returning 0x1234, ACC_CYCLES=2 → Mem_OE low exactly 2 cycles; cpu_ack one pulse 3 cycles after the IDLE edge; cpu_rdata=0x1234; dma_ack never asserted.
- DMA write addr 0xABCDE, data 0x5A5A → Data_oe=1 and Mem_WE low 2 cycles, ADDR=0xABCDE stable throughout; SRAM model holds 0x5A5A; Mem_OE stays 1.
- CPU and DMA request continuously with MAX_WAIT=8 → 8 consecutive CPU grants, then 1 DMA grant, repeating; no cycle has both acks.
- Assert Reset during the 2nd ACCESS cycle of a write → next edge Mem_WE=1, Data_oe=0, busy=0, no ack; a following CPU read completes normally.
- With MEM_ARB_ROUND_ROBIN_EN, both ports request continuously → grants alternate CPU, DMA, CPU, DMA…, starting with CPU after reset.
- Back-to-back CPU reads with req held high through IDLE → next access starts exactly one IDLE cycle after DONE; period = 4 cycles at ACC_CYCLES=2.
